ram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the DPI-backed RAM controller (`RAMCtrl`). It shares the single RAM port between the instruction-fetch requester (read-only) and the load/store requester (read/write) using valid/ready handshakes. It also absorbs the RAM's fixed one-cycle registered read latency and holds each response until the owner accepts it. It sits between IFU/LSU and `RAMCtrl` in the NPC core.

---
 rtl/ram_arb_pkg.sv | 31 +++
 rtl/ram_arbiter_strb2mask.sv | 16 +
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the IFU/LSU to RAMCtrl arbiter.
package ram_arb_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [XLEN-1:0] ADDR_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Write-port payload held toward RAMCtrl between writes.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] wmask;
  } ram_wr_t;

  function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ram_arbiter_strb2mask.sv
// Expands 8 byte strobes into a 64-bit bit mask (byte i -> {8{strb[i]}}).
module strb2mask
  import ram_arb_pkg::*;
(
  input  logic [STRB_W-1:0] strb,
  output logic [XLEN-1:0]   mask_c
);

  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      mask_c[i*8 +: 8] = {8{strb[i]}};
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single RAMCtrl port between instruction fetch and load/store,
// absorbing the one-cycle read latency and holding responses until accepted.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned     MAX_DATA_BURST = 4,
  parameter logic [XLEN-1:0] RESET_ADDR     = 64'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inst_req_valid,
  output logic              inst_req_ready,
  input  logic [XLEN-1:0]   inst_req_addr,
  output logic              inst_resp_valid,
  input  logic              inst_resp_ready,
  output logic [XLEN-1:0]   inst_resp_rdata,
  input  logic              data_req_valid,
  output logic              data_req_ready,
  input  logic [XLEN-1:0]   data_req_addr,
  input  logic              data_req_wen,
  input  logic [XLEN-1:0]   data_req_wdata,
  input  logic [STRB_W-1:0] data_req_wstrb,
  output logic              data_resp_valid,
  input  logic              data_resp_ready,
  output logic [XLEN-1:0]   data_resp_rdata,
  output logic [XLEN-1:0]   ram_raddr,
  output logic [XLEN-1:0]   ram_waddr,
  input  logic [XLEN-1:0]   ram_rdata,
  output logic              ram_rflag,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [XLEN-1:0]   ram_wmask,
  output logic              ram_wen
);

  localparam int unsigned CNT_W = $clog2(MAX_DATA_BURST + 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [XLEN-1:0]   resp_buf_q, resp_buf_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [XLEN-1:0]   raddr_q, raddr_d;
  ram_wr_t           wr_q, wr_d;
  logic [XLEN-1:0]   wmask_c;
  logic              rd_issue;
  logic              wr_issue;
  logic              inst_starved;

  strb2mask u_strb2mask (
    .strb   (data_req_wstrb),
    .mask_c (wmask_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_INST;
      resp_buf_q  <= '0;
      burst_cnt_q <= '0;
      raddr_q     <= RESET_ADDR;
      wr_q        <= '{addr: RESET_ADDR, wdata: '0, wmask: '0};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      resp_buf_q  <= resp_buf_d;
      burst_cnt_q <= burst_cnt_d;
      raddr_q     <= raddr_d;
      wr_q        <= wr_d;
    end
  end

  assign inst_starved = inst_req_valid && (burst_cnt_q == CNT_W'(MAX_DATA_BURST));

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    resp_buf_d      = resp_buf_q;
    burst_cnt_d     = burst_cnt_q;
    raddr_d         = raddr_q;
    wr_d            = wr_q;
    inst_req_ready  = 1'b0;
    data_req_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    data_resp_valid = 1'b0;
    rd_issue        = 1'b0;
    wr_issue        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed during reset so no write leaks to RAMCtrl.
        if (!reset) begin
          if (data_req_valid && !inst_starved) begin
            data_req_ready = 1'b1;
            owner_d        = OWN_DATA;
            if (data_req_wen) begin
              wr_issue   = 1'b1;
              wr_d       = '{addr: align_addr(data_req_addr), wdata: data_req_wdata, wmask: wmask_c};
              resp_buf_d = '0;
              state_d    = ST_RESP;
            end else begin
              rd_issue = 1'b1;
              raddr_d  = align_addr(data_req_addr);
              state_d  = ST_RD_WAIT;
            end
          end else if (inst_req_valid) begin
            inst_req_ready = 1'b1;
            owner_d        = OWN_INST;
            rd_issue       = 1'b1;
            raddr_d        = align_addr(inst_req_addr);
            state_d        = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        resp_buf_d = ram_rdata;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        inst_resp_valid = (owner_q == OWN_INST);
        data_resp_valid = (owner_q == OWN_DATA);
        if ((inst_resp_valid && inst_resp_ready) || (data_resp_valid && data_resp_ready)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Starvation guard: count data grants only while fetch is waiting.
    if (!inst_req_valid || inst_req_ready) begin
      burst_cnt_d = '0;
    end else if (data_req_ready) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  assign ram_raddr       = raddr_d;
  assign ram_rflag       = rd_issue;
  assign ram_waddr       = wr_d.addr;
  assign ram_wdata       = wr_d.wdata;
  assign ram_wmask       = wr_d.wmask;
  assign ram_wen         = wr_issue;
  assign inst_resp_rdata = resp_buf_q;
  assign data_resp_rdata = resp_buf_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, scoreboard, and
// hand-written sequences for arbitration, backpressure and reset.
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        inst_req_valid, inst_req_ready;
  logic [63:0] inst_req_addr;
  logic        inst_resp_valid, inst_resp_ready;
  logic [63:0] inst_resp_rdata;
  logic        data_req_valid, data_req_ready;
  logic [63:0] data_req_addr;
  logic        data_req_wen;
  logic [63:0] data_req_wdata;
  logic [7:0]  data_req_wstrb;
  logic        data_resp_valid, data_resp_ready;
  logic [63:0] data_resp_rdata;
  logic [63:0] ram_raddr, ram_waddr, ram_rdata, ram_wdata, ram_wmask;
  logic        ram_rflag, ram_wen;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] mem    [0:255];
  logic [63:0] shadow [0:255];
  logic [63:0] inst_q [$];
  logic [63:0] data_q [$];

  typedef struct {
    bit is_data;
    int cyc;
  } grant_t;
  grant_t grant_log [$];

  typedef struct {
    bit          is_data;
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp_addr;
    logic [63:0] exp_mask;
    int          exp_lat;
  } vec_t;
  vec_t vecs [11];

  ram_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .inst_req_addr   (inst_req_addr),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_ready (inst_resp_ready),
    .inst_resp_rdata (inst_resp_rdata),
    .data_req_valid  (data_req_valid),
    .data_req_ready  (data_req_ready),
    .data_req_addr   (data_req_addr),
    .data_req_wen    (data_req_wen),
    .data_req_wdata  (data_req_wdata),
    .data_req_wstrb  (data_req_wstrb),
    .data_resp_valid (data_resp_valid),
    .data_resp_ready (data_resp_ready),
    .data_resp_rdata (data_resp_rdata),
    .ram_raddr       (ram_raddr),
    .ram_waddr       (ram_waddr),
    .ram_rdata       (ram_rdata),
    .ram_rflag       (ram_rflag),
    .ram_wdata       (ram_wdata),
    .ram_wmask       (ram_wmask),
    .ram_wen         (ram_wen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAMCtrl model: registered read every cycle, masked write.
  always @(posedge clock) begin
    ram_rdata <= mem[ram_raddr[10:3]];
    if (ram_wen) mem[ram_waddr[10:3]] <= (mem[ram_waddr[10:3]] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Scoreboard: response data popped when the owner accepts it.
  always @(negedge clock) begin
    if (inst_resp_valid && inst_resp_ready) begin
      if (inst_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst_resp_unexpected: actual rdata %h required no response", inst_resp_rdata);
      end else chk("inst_resp_rdata", inst_resp_rdata, inst_q.pop_front());
    end
    if (data_resp_valid && data_resp_ready) begin
      if (data_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_resp_unexpected: actual rdata %h required no response", data_resp_rdata);
      end else chk("data_resp_rdata", data_resp_rdata, data_q.pop_front());
    end
  end

  function automatic void push_expected(input bit is_data, input bit wen, input logic [63:0] addr,
                                        input logic [63:0] wdata, input logic [7:0] wstrb);
    int idx;
    idx = int'(addr[10:3]);
    if (wen) begin
      for (int b = 0; b < 8; b++) if (wstrb[b]) shadow[idx][b*8 +: 8] = wdata[b*8 +: 8];
      data_q.push_back(64'd0);
    end else if (is_data) data_q.push_back(shadow[idx]);
    else inst_q.push_back(shadow[idx]);
  endfunction

  task automatic drive_port(input bit is_data, input bit wen, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wstrb, input bit expect_resp);
    int  n;
    logic rdy;
    @(posedge clock); #1;
    if (expect_resp) push_expected(is_data, wen, addr, wdata, wstrb);
    if (is_data) begin
      data_req_valid = 1'b1; data_req_addr = addr; data_req_wen = wen;
      data_req_wdata = wdata; data_req_wstrb = wstrb;
    end else begin
      inst_req_valid = 1'b1; inst_req_addr = addr;
    end
    n = 0;
    do begin
      @(negedge clock);
      rdy = is_data ? data_req_ready : inst_req_ready;
      n++;
    end while (!rdy && n < 64);
    if (rdy) grant_log.push_back('{is_data, cyc});
    else chk1(is_data ? "data_grant_timeout" : "inst_grant_timeout", rdy, 1'b1);
    @(posedge clock); #1;
    if (is_data) data_req_valid = 1'b0;
    else inst_req_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int   n;
    logic rdy, rv;
    @(posedge clock); #1;
    push_expected(v.is_data, v.wen, v.addr, v.wdata, v.wstrb);
    if (v.is_data) begin
      data_req_valid = 1'b1; data_req_addr = v.addr; data_req_wen = v.wen;
      data_req_wdata = v.wdata; data_req_wstrb = v.wstrb;
    end else begin
      inst_req_valid = 1'b1; inst_req_addr = v.addr;
    end
    n = 0;
    do begin
      @(negedge clock);
      rdy = v.is_data ? data_req_ready : inst_req_ready;
      n++;
    end while (!rdy && n < 64);
    chk1("txn_grant", rdy, 1'b1);
    if (v.wen) begin
      chk1("wr_wen", ram_wen, 1'b1);
      chk1("wr_rflag", ram_rflag, 1'b0);
      chk("wr_waddr", ram_waddr, v.exp_addr);
      chk("wr_wdata", ram_wdata, v.wdata);
      chk("wr_wmask", ram_wmask, v.exp_mask);
    end else begin
      chk1("rd_rflag", ram_rflag, 1'b1);
      chk1("rd_wen", ram_wen, 1'b0);
      chk("rd_raddr", ram_raddr, v.exp_addr);
    end
    @(posedge clock); #1;
    data_req_valid = 1'b0;
    inst_req_valid = 1'b0;
    n = 1;
    @(negedge clock);
    chk1("issue_one_cycle_rflag", ram_rflag, 1'b0);
    chk1("issue_one_cycle_wen", ram_wen, 1'b0);
    chk("addr_hold", v.wen ? ram_waddr : ram_raddr, v.exp_addr);
    rv = v.is_data ? data_resp_valid : inst_resp_valid;
    while (!rv && n < 16) begin
      @(negedge clock);
      n++;
      rv = v.is_data ? data_resp_valid : inst_resp_valid;
    end
    chk_int("resp_latency", n, v.exp_lat);
    chk1("other_resp_valid", v.is_data ? inst_resp_valid : data_resp_valid, 1'b0);
    @(posedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_inst_ready"}, inst_req_ready, 1'b0);
    chk1({tag, "_data_ready"}, data_req_ready, 1'b0);
    chk1({tag, "_inst_resp_valid"}, inst_resp_valid, 1'b0);
    chk1({tag, "_data_resp_valid"}, data_resp_valid, 1'b0);
    chk1({tag, "_rflag"}, ram_rflag, 1'b0);
    chk1({tag, "_wen"}, ram_wen, 1'b0);
    chk({tag, "_raddr"}, ram_raddr, 64'h8000_0000);
    chk({tag, "_waddr"}, ram_waddr, 64'h8000_0000);
    chk({tag, "_wdata"}, ram_wdata, 64'd0);
    chk({tag, "_wmask"}, ram_wmask, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [9:0]  exp_order;

    for (int i = 0; i < 256; i++) begin
      mem[i]    = {32'hCAFE_0000 ^ 32'(i), 32'(i) * 32'h0101_0101};
      shadow[i] = {32'hCAFE_0000 ^ 32'(i), 32'(i) * 32'h0101_0101};
    end

    vecs[0]  = '{1'b0, 1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'h8000_0000, 64'd0, 2};
    vecs[1]  = '{1'b1, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 64'h8000_0010, 64'h0000_0000_FFFF_FFFF, 1};
    vecs[2]  = '{1'b1, 1'b0, 64'h8000_0013, 64'd0, 8'h00, 64'h8000_0010, 64'd0, 2};
    vecs[3]  = '{1'b1, 1'b1, 64'h8000_0020, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 64'h8000_0020, 64'd0, 1};
    vecs[4]  = '{1'b1, 1'b0, 64'h8000_0020, 64'd0, 8'h00, 64'h8000_0020, 64'd0, 2};
    vecs[5]  = '{1'b1, 1'b1, 64'h8000_002D, 64'hA1A2_A3A4_A5A6_A7A8, 8'hA5, 64'h8000_0028, 64'hFF00_FF00_00FF_00FF, 1};
    vecs[6]  = '{1'b0, 1'b0, 64'h8000_002F, 64'd0, 8'h00, 64'h8000_0028, 64'd0, 2};
    vecs[7]  = '{1'b1, 1'b1, 64'h8000_0030, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h8000_0030, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[8]  = '{1'b1, 1'b1, 64'h8000_0038, 64'hFEDC_BA98_7654_3210, 8'h80, 64'h8000_0038, 64'hFF00_0000_0000_0000, 1};
    vecs[9]  = '{1'b0, 1'b0, 64'h8000_003C, 64'd0, 8'h00, 64'h8000_0038, 64'd0, 2};
    vecs[10] = '{1'b0, 1'b0, 64'h8000_0064, 64'd0, 8'h00, 64'h8000_0060, 64'd0, 2};

    reset = 1'b1;
    inst_req_valid = 1'b0; inst_req_addr = '0;
    data_req_valid = 1'b0; data_req_addr = '0; data_req_wen = 1'b0;
    data_req_wdata = '0;   data_req_wstrb = '0;
    inst_resp_ready = 1'b1; data_resp_ready = 1'b1;

    // A write presented during reset must not reach the RAM.
    repeat (2) @(posedge clock);
    #1;
    data_req_valid = 1'b1; data_req_wen = 1'b1; data_req_addr = 64'h8000_0008;
    data_req_wdata = 64'hFFFF_0000_FFFF_0000; data_req_wstrb = 8'hFF;
    @(negedge clock);
    chk1("reset_write_ready", data_req_ready, 1'b0);
    chk1("reset_write_wen", ram_wen, 1'b0);
    @(posedge clock); #1;
    data_req_valid = 1'b0; data_req_wen = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("por");

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Simultaneous requests: data first, fetch in the following IDLE.
    grant_log.delete();
    fork
      drive_port(1'b0, 1'b0, 64'h8000_0040, 64'd0, 8'h00, 1'b1);
      drive_port(1'b1, 1'b0, 64'h8000_0048, 64'd0, 8'h00, 1'b1);
    join
    repeat (4) @(posedge clock);
    chk_int("simul_grants", grant_log.size(), 2);
    chk1("simul_first_is_data", grant_log[0].is_data, 1'b1);
    chk1("simul_second_is_inst", grant_log[1].is_data, 1'b0);
    chk_int("simul_grant_gap", grant_log[1].cyc - grant_log[0].cyc, 3);

    // Starvation guard: four data grants, then one fetch, repeating.
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 8; k++)
          drive_port(1'b1, 1'b1, 64'h8000_0080 + 64'(8 * k), 64'h5A5A_0000_0000_0000 | 64'(k), 8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++)
          drive_port(1'b0, 1'b0, 64'h8000_00C0 + 64'(8 * k), 64'd0, 8'h00, 1'b1);
      end
    join
    repeat (4) @(posedge clock);
    exp_order = 10'b11110_11110;
    chk_int("starve_grants", grant_log.size(), 10);
    for (int i = 0; i < 10; i++) chk1("starve_order", grant_log[i].is_data, exp_order[9-i]);

    // Backpressure on a data read with a fetch waiting behind it.
    data_resp_ready = 1'b0;
    drive_port(1'b1, 1'b0, 64'h8000_0050, 64'd0, 8'h00, 1'b1);
    push_expected(1'b0, 1'b0, 64'h8000_0058, 64'd0, 8'h00);
    inst_req_valid = 1'b1; inst_req_addr = 64'h8000_0058;
    @(negedge clock);
    chk1("bp_inst_ready_rdwait", inst_req_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk1("bp_data_resp_valid", data_resp_valid, 1'b1);
      chk("bp_data_resp_rdata", data_resp_rdata, shadow[10]);
      chk("bp_no_grant", {60'd0, inst_req_ready, data_req_ready, ram_rflag, ram_wen}, 64'd0);
    end
    @(posedge clock); #1;
    data_resp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!inst_req_ready && n < 16);
    chk1("bp_inst_granted", inst_req_ready, 1'b1);
    chk_int("bp_inst_grant_delay", n, 2);
    @(posedge clock); #1;
    inst_req_valid = 1'b0;
    repeat (4) @(posedge clock);

    // Reset while in RD_WAIT: response dropped, outputs back to reset values.
    drive_port(1'b0, 1'b0, 64'h8000_0068, 64'd0, 8'h00, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("rst_rdwait");
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk1("rst_no_inst_resp", inst_resp_valid, 1'b0);
    end
    run_txn(vecs[10]);

    repeat (3) @(posedge clock);
    chk_int("inst_q_drained", inst_q.size(), 0);
    chk_int("data_q_drained", data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
